// File: rtl/bus_master_arb_pkg.sv
// bus_master_arb_pkg: FSM encoding, default error data and width helpers shared by the bus master arbiter
package bus_master_arb_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;
   localparam int CNT_W = 8;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/bus_master_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first requester at or after the pointer wins
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IW   = 1
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_gnt,
   output logic [IW-1:0]   o_idx
);
   // scan from the farthest slot back to the pointer so the nearest requester is written last
   always_comb begin
      o_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--)
         if (i_req[(int'(i_ptr) + k) % NREQ]) o_idx = IW'((int'(i_ptr) + k) % NREQ);
      o_gnt = (|i_req) ? (NREQ'(1) << o_idx) : '0;
   end
endmodule

// File: rtl/bus_master_arb.sv
// bus_master_arb: round-robin sharing of the register-bus master port; BUS_MASTER_ARB_TIMEOUT_EN adds a no-ack timeout
module bus_master_arb
   import bus_master_arb_pkg::*;
#(
   parameter int             NREQ     = 2,
   parameter int             AW       = 16,
   parameter int             DW       = 32,
   parameter int             TIMEOUT  = 16,
   parameter logic [DW-1:0]  ERR_DATA = DW'(DEF_ERR_DATA)
) (
   input  logic             bus_clk,
   input  logic             bus_reset_l,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ-1:0]  rd_wr_l,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] wr_data,
   output logic [NREQ-1:0]  done,
   output logic [DW-1:0]    rd_data,
   output logic             err,
   output logic             bus_req,
   output logic             bus_rd_wr_l,
   output logic [AW-1:0]    bus_addr,
   output logic [DW-1:0]    bus_wr_data,
   input  logic             bus_ack,
   input  logic [DW-1:0]    bus_rd_data
);
   localparam int IW = idx_w(NREQ);
   state_t r_state, w_state;
   logic [NREQ-1:0] r_done, w_done, r_goh, w_goh, w_arb_gnt;
   logic [IW-1:0] r_gidx, w_gidx, r_ptr, w_ptr, w_arb_idx;
   logic [DW-1:0] r_rd_data, w_rd_data, r_wr_data, w_wr_data;
   logic [AW-1:0] r_addr, w_addr;
   logic r_bus_req, w_bus_req, r_rd_wr_l, w_rd_wr_l;
`ifdef BUS_MASTER_ARB_TIMEOUT_EN
   logic [CNT_W-1:0] r_cnt, w_cnt;
   logic r_err, w_err;
   assign err = r_err;
`else
   assign err = 1'b0;
`endif
   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
      .i_req (req),
      .i_ptr (r_ptr),
      .o_gnt (w_arb_gnt),
      .o_idx (w_arb_idx)
   );
   assign done        = r_done;
   assign rd_data     = r_rd_data;
   assign bus_req     = r_bus_req;
   assign bus_rd_wr_l = r_rd_wr_l;
   assign bus_addr    = r_addr;
   assign bus_wr_data = r_wr_data;
   // next state and next register values; every output is registered from these
   always_comb begin
      w_state   = r_state;
      w_done    = '0;
      w_bus_req = 1'b0;
      w_rd_data = r_rd_data;
      w_rd_wr_l = r_rd_wr_l;
      w_addr    = r_addr;
      w_wr_data = r_wr_data;
      w_gidx    = r_gidx;
      w_goh     = r_goh;
      w_ptr     = r_ptr;
`ifdef BUS_MASTER_ARB_TIMEOUT_EN
      w_err     = r_err;
      w_cnt     = r_cnt;
`endif
      case (r_state)
         IDLE: if (|req) begin
            w_state   = ISSUE;
            w_bus_req = 1'b1;
            w_rd_wr_l = rd_wr_l[w_arb_idx];
            w_addr    = addr[w_arb_idx*AW +: AW];
            w_wr_data = wr_data[w_arb_idx*DW +: DW];
            w_gidx    = w_arb_idx;
            w_goh     = w_arb_gnt;
         end
         ISSUE: begin
            w_state = WAIT;
`ifdef BUS_MASTER_ARB_TIMEOUT_EN
            w_cnt   = '0;
`endif
         end
         WAIT: if (bus_ack) begin
            w_state   = DONE;
            w_done    = r_goh;
            w_rd_data = bus_rd_data;
`ifdef BUS_MASTER_ARB_TIMEOUT_EN
            w_err     = 1'b0;
`endif
         end
`ifdef BUS_MASTER_ARB_TIMEOUT_EN
         else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            w_state   = DONE;
            w_done    = r_goh;
            w_rd_data = ERR_DATA;
            w_err     = 1'b1;
         end
         else w_cnt = r_cnt + 1'b1;
`endif
         default: begin
            w_state = IDLE;
            w_ptr   = (int'(r_gidx) == NREQ - 1) ? '0 : r_gidx + 1'b1;
         end
      endcase
   end
   // state and output registers; reset drops any transaction in flight
   always_ff @(posedge bus_clk or negedge bus_reset_l) begin
      if (!bus_reset_l) begin
         r_state   <= IDLE;
         r_done    <= '0;
         r_bus_req <= 1'b0;
         r_rd_data <= '0;
         r_rd_wr_l <= 1'b1;
         r_addr    <= '0;
         r_wr_data <= '0;
         r_gidx    <= '0;
         r_goh     <= '0;
         r_ptr     <= '0;
`ifdef BUS_MASTER_ARB_TIMEOUT_EN
         r_err     <= 1'b0;
         r_cnt     <= '0;
`endif
      end else begin
         r_state   <= w_state;
         r_done    <= w_done;
         r_bus_req <= w_bus_req;
         r_rd_data <= w_rd_data;
         r_rd_wr_l <= w_rd_wr_l;
         r_addr    <= w_addr;
         r_wr_data <= w_wr_data;
         r_gidx    <= w_gidx;
         r_goh     <= w_goh;
         r_ptr     <= w_ptr;
`ifdef BUS_MASTER_ARB_TIMEOUT_EN
         r_err     <= w_err;
         r_cnt     <= w_cnt;
`endif
      end
   end
endmodule

// File: tb/tb_bus_master_arb.sv
// tb_bus_master_arb: directed vector table, multi-cycle corner sequences and randomized traffic against a transaction model
module tb_bus_master_arb;
   localparam int NREQ = 2;
   localparam int AW   = 16;
   localparam int DW   = 32;
   localparam int TO   = 16;

   logic bus_clk = 1'b0;
   logic bus_reset_l = 1'b1;
   logic [NREQ-1:0] req = '0;
   logic [NREQ-1:0] rd_wr_l;
   logic [NREQ*AW-1:0] addr;
   logic [NREQ*DW-1:0] wr_data;
   logic [NREQ-1:0] done;
   logic [DW-1:0] rd_data;
   logic err, bus_req, bus_rd_wr_l;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wr_data;
   logic bus_ack = 1'b0;
   logic [DW-1:0] bus_rd_data = '0;

   logic f_rd [NREQ];
   logic [AW-1:0] f_addr [NREQ];
   logic [DW-1:0] f_wd [NREQ];
   logic [31:0] mem [256];
   int sl_cnt = -1;
   logic [31:0] sl_data = '0;
   int slave_lat = 0;
   bit stray = 1'b0;
   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [NREQ-1:0] mask;
      logic rd0; logic [15:0] a0; logic [31:0] d0;
      logic rd1; logic [15:0] a1; logic [31:0] d1;
      int lat; int g; logic [31:0] exp_d;
   } vec_t;

   bus_master_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .bus_clk(bus_clk), .bus_reset_l(bus_reset_l), .req(req), .rd_wr_l(rd_wr_l),
      .addr(addr), .wr_data(wr_data), .done(done), .rd_data(rd_data), .err(err),
      .bus_req(bus_req), .bus_rd_wr_l(bus_rd_wr_l), .bus_addr(bus_addr),
      .bus_wr_data(bus_wr_data), .bus_ack(bus_ack), .bus_rd_data(bus_rd_data)
   );

   always #5 bus_clk = ~bus_clk;

   always_comb
      for (int i = 0; i < NREQ; i++) begin
         rd_wr_l[i] = f_rd[i];
         addr[i*AW +: AW] = f_addr[i];
         wr_data[i*DW +: DW] = f_wd[i];
      end

   // register-file slave: addresses below 0x100 are mapped and ack after slave_lat WAIT cycles
   always @(posedge bus_clk) begin
      #1;
      bus_ack = 1'b0;
      bus_rd_data = '0;
      if (sl_cnt == 0) begin
         bus_ack = 1'b1;
         bus_rd_data = sl_data;
      end
      if (sl_cnt >= 0) sl_cnt--;
      if (stray) begin
         bus_ack = 1'b1;
         bus_rd_data = 32'h1111_2222;
         stray = 1'b0;
      end
      if (!bus_reset_l) sl_cnt = -1;
      else if (bus_req && bus_addr < 16'h0100) begin
         sl_cnt = slave_lat;
         sl_data = bus_rd_wr_l ? mem[bus_addr[7:0]] : 32'h0;
         if (!bus_rd_wr_l) mem[bus_addr[7:0]] = bus_wr_data;
      end
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++)
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   task automatic do_reset();
      req = '0;
      bus_reset_l = 1'b0;
      #1;
      chk("reset_async", {done, rd_data, err, bus_req, bus_rd_wr_l, bus_addr, bus_wr_data},
          {{NREQ{1'b0}}, 32'h0, 1'b0, 1'b0, 1'b1, 16'h0, 32'h0});
      @(posedge bus_clk); #2;
      chk("reset_held", {done, rd_data, err, bus_req, bus_rd_wr_l, bus_addr, bus_wr_data},
          {{NREQ{1'b0}}, 32'h0, 1'b0, 1'b0, 1'b1, 16'h0, 32'h0});
      bus_reset_l = 1'b1;
      @(posedge bus_clk); #2;
   endtask

   task automatic txn(input logic [NREQ-1:0] mask, input int lat, input int g,
                      input logic [31:0] exp_d, input logic exp_e, input int exp_c);
      int c;
      logic [48:0] fld;
      fld = {f_rd[g], f_addr[g], f_wd[g]};
      slave_lat = lat;
      req = mask;
      @(posedge bus_clk); #2; c = 1;
      chk("bus_req_cycle1", bus_req, 1'b1);
      chk("bus_fields", {bus_rd_wr_l, bus_addr, bus_wr_data}, fld);
      @(posedge bus_clk); #2; c = 2;
      chk("bus_req_one_cycle", bus_req, 1'b0);
      while (done == '0 && c < exp_c + 5) begin
         @(posedge bus_clk); #2; c++;
      end
      chk("done_cycle", c, exp_c);
      chk("done_grant", done, 1 << g);
      chk("done_data", {err, rd_data}, {exp_e, exp_d});
      chk("bus_stable", {bus_rd_wr_l, bus_addr, bus_wr_data}, fld);
      req = '0;
      @(posedge bus_clk); #2;
      chk("done_one_cycle_hold", {done, err, rd_data}, {{NREQ{1'b0}}, exp_e, exp_d});
   endtask

   task automatic stray_chk(input logic [31:0] exp_d, input logic exp_e);
      stray = 1'b1;
      repeat (4) begin
         @(posedge bus_clk); #2;
         chk("stray_ack_ignored", {done, err, rd_data}, {{NREQ{1'b0}}, exp_e, exp_d});
      end
   endtask

   vec_t tbl [8];
   bit pend [NREQ];
   int pm, eb, eg, edc, w;
   logic [31:0] ed;
   logic [NREQ-1:0] eoh;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'(i);
      mem[16] = 32'h1234_5678;
      for (int i = 0; i < NREQ; i++) begin
         f_rd[i] = 1'b1; f_addr[i] = '0; f_wd[i] = '0; pend[i] = 1'b0;
      end
      tbl[0] = '{2'b01, 1'b1, 16'h0010, 32'h0,         1'b1, 16'h0000, 32'h0,         0, 0, 32'h1234_5678};
      tbl[1] = '{2'b10, 1'b1, 16'h0010, 32'h0,         1'b0, 16'h0020, 32'hA5A5_A5A5, 0, 1, 32'h0};
      tbl[2] = '{2'b10, 1'b1, 16'h0010, 32'h0,         1'b1, 16'h0020, 32'h0,         1, 1, 32'hA5A5_A5A5};
      tbl[3] = '{2'b11, 1'b1, 16'h0010, 32'h0,         1'b1, 16'h0020, 32'h0,         2, 0, 32'h1234_5678};
      tbl[4] = '{2'b11, 1'b1, 16'h0010, 32'h0,         1'b1, 16'h0020, 32'h0,         0, 1, 32'hA5A5_A5A5};
      tbl[5] = '{2'b11, 1'b0, 16'h0030, 32'h0BAD_F00D, 1'b1, 16'h0020, 32'h0,         3, 0, 32'h0};
      tbl[6] = '{2'b01, 1'b1, 16'h0030, 32'h0,         1'b1, 16'h0020, 32'h0,         0, 0, 32'h0BAD_F00D};
      tbl[7] = '{2'b01, 1'b1, 16'h0010, 32'h0,         1'b1, 16'h0020, 32'h0,         0, 0, 32'h1234_5678};
      #3;
      do_reset();
      for (int v = 0; v < 8; v++) begin
         f_rd[0] = tbl[v].rd0; f_addr[0] = tbl[v].a0; f_wd[0] = tbl[v].d0;
         f_rd[1] = tbl[v].rd1; f_addr[1] = tbl[v].a1; f_wd[1] = tbl[v].d1;
         txn(tbl[v].mask, tbl[v].lat, tbl[v].g, tbl[v].exp_d, 1'b0, 3 + tbl[v].lat);
      end
      stray_chk(32'h1234_5678, 1'b0);

      f_rd[0] = 1'b1; f_addr[0] = 16'h7FFF; slave_lat = 0; req = 2'b01;
      repeat (4) @(posedge bus_clk);
      #2;
      chk("wait_in_progress", {done, bus_req, bus_addr}, {{NREQ{1'b0}}, 1'b0, 16'h7FFF});
      do_reset();
      f_addr[0] = 16'h0010;
      txn(2'b01, 0, 0, 32'h1234_5678, 1'b0, 3);

`ifdef BUS_MASTER_ARB_TIMEOUT_EN
      f_rd[0] = 1'b1; f_addr[0] = 16'h7FFF;
      txn(2'b01, 0, 0, 32'hDEAD_BEEF, 1'b1, 2 + TO);
      @(posedge bus_clk); #2;
      stray_chk(32'hDEAD_BEEF, 1'b1);
      f_addr[0] = 16'h0010;
      txn(2'b01, TO - 1, 0, 32'h1234_5678, 1'b0, 2 + TO);
      txn(2'b01, TO - 2, 0, 32'h1234_5678, 1'b0, 1 + TO);
`else
      f_rd[1] = 1'b1; f_addr[1] = 16'h0020;
      txn(2'b10, 40, 1, 32'hA5A5_A5A5, 1'b0, 43);
`endif

      do_reset();
      f_rd[0] = 1'b1; f_addr[0] = 16'h0010; f_wd[0] = '0;
      f_rd[1] = 1'b1; f_addr[1] = 16'h0020; f_wd[1] = '0;
      slave_lat = 0;
      req = 2'b11;
      begin : hold_all
         int bq[$];
         int dn[$];
         logic [NREQ-1:0] dg[$];
         for (int c = 1; c <= 40 && dn.size() < 4; c++) begin
            @(posedge bus_clk); #2;
            if (bus_req) bq.push_back(c);
            if (done != '0) begin
               dn.push_back(c);
               dg.push_back(done);
               if (dn.size() == 4) req = '0;
            end
         end
         chk("hold_done_count", dn.size(), 4);
         for (int k = 0; k < dn.size(); k++) begin
            chk("hold_grant", dg[k], (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k < bq.size()) chk("hold_latency", dn[k] - bq[k], 2);
         end
         for (int k = 1; k < bq.size(); k++) chk("hold_gap", bq[k] - bq[k-1], 4);
      end

      do_reset();
      pm = 0; eb = 0; eg = 0; edc = 0; ed = '0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(posedge bus_clk); #2;
         if (bus_req) begin
            w = rr_pick(req, pm);
            chk("rnd_overlap", eb, 0);
            if (w < 0) chk("rnd_grant_valid", w, 0);
            else begin
               chk("rnd_fields", {bus_rd_wr_l, bus_addr, bus_wr_data}, {f_rd[w], f_addr[w], f_wd[w]});
               eb = 1; eg = w; edc = cyc + 2 + slave_lat;
               ed = f_rd[w] ? mem[f_addr[w][7:0]] : 32'h0;
            end
         end
         if (done != '0 || (eb != 0 && cyc == edc)) begin
            if (eb != 0 && cyc == edc) begin
               eoh = '0;
               eoh[eg] = 1'b1;
               chk("rnd_done", {done, err, rd_data}, {eoh, 1'b0, ed});
               eb = 0; pend[eg] = 1'b0; pm = (eg + 1) % NREQ;
            end else chk("rnd_spurious_done", done, 0);
         end
         for (int i = 0; i < NREQ; i++)
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               f_rd[i] = 1'($urandom_range(0, 1));
               f_addr[i] = 16'($urandom_range(0, 15) * 4);
               f_wd[i] = $urandom;
            end
         for (int i = 0; i < NREQ; i++) req[i] = pend[i];
         slave_lat = $urandom_range(0, 4);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
